imem_loader: RTL and testbench

- Writer side of the instruction memory: accepts a byte stream over a valid/ready handshake, assembles 16-bit instruction words, and drives write strobes into instruction memory at incrementing addresses.
- Holds the CPU via `cpu_hold` while a load is in progress and releases it when the load completes.
- Sits beside `instruction_memory`, feeding its write port. The CPU's PC-driven read port is unaffected.

---
 rtl/imem_loader.sv | 164 ++++++++++++++++
 tb/tb_imem_loader.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Byte-stream instruction memory loader: big-endian length header, then 16-bit words written at
// incrementing addresses while the CPU is held. Define LOADER_CHECKSUM_EN to require a trailing 16-bit sum.
module imem_loader #(
  parameter int ADDR_W    = 16,
  parameter int MEM_WORDS = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [15:0]       wr_data,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_LEN_HI  = 4'd1;
  localparam logic [3:0] S_LEN_LO  = 4'd2;
  localparam logic [3:0] S_DATA_HI = 4'd3;
  localparam logic [3:0] S_DATA_LO = 4'd4;
  localparam logic [3:0] S_WRITE   = 4'd5;
  localparam logic [3:0] S_DONE    = 4'd6;
  localparam logic [3:0] S_ERROR   = 4'd7;
`ifdef LOADER_CHECKSUM_EN
  localparam logic [3:0] S_CHK_HI  = 4'd8;
  localparam logic [3:0] S_CHK_LO  = 4'd9;
`endif

  localparam logic [15:0] MAX_LEN = 16'(MEM_WORDS);

  logic [3:0]        state_reg, state_next;
  logic [15:0]       len_reg;
  logic [15:0]       count_reg;
  logic [7:0]        hi_reg;
  logic [ADDR_W-1:0] wr_addr_reg;
  logic [15:0]       wr_data_reg;
`ifdef LOADER_CHECKSUM_EN
  logic [15:0]       sum_reg;
`endif

  logic        xfer;
  logic [15:0] len_word;
  logic [15:0] byte_word;
  logic        last_word;

  assign xfer      = in_valid & in_ready;
  assign len_word  = {len_reg[15:8], in_data};
  assign byte_word = {hi_reg, in_data};
  assign last_word = ((count_reg + 16'd1) == len_reg);

  assign wr_addr = wr_addr_reg;
  assign wr_data = wr_data_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Datapath registers; wr_addr/wr_data keep the last written word after the load.
  always_ff @(posedge clk) begin
    if (reset) begin
      len_reg     <= '0;
      count_reg   <= '0;
      hi_reg      <= '0;
      wr_addr_reg <= '0;
      wr_data_reg <= '0;
`ifdef LOADER_CHECKSUM_EN
      sum_reg     <= '0;
`endif
    end else begin
      case (state_reg)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            count_reg <= '0;
`ifdef LOADER_CHECKSUM_EN
            sum_reg   <= '0;
`endif
          end
        end
        S_LEN_HI:  if (xfer) len_reg[15:8] <= in_data;
        S_LEN_LO:  if (xfer) len_reg[7:0]  <= in_data;
        S_DATA_HI: if (xfer) hi_reg        <= in_data;
        S_DATA_LO: begin
          if (xfer) begin
            wr_data_reg <= byte_word;
            wr_addr_reg <= ADDR_W'(count_reg);
          end
        end
        S_WRITE: begin
          count_reg <= count_reg + 16'd1;
`ifdef LOADER_CHECKSUM_EN
          sum_reg   <= sum_reg + wr_data_reg;
`endif
        end
`ifdef LOADER_CHECKSUM_EN
        S_CHK_HI:  if (xfer) hi_reg <= in_data;
`endif
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE, S_DONE, S_ERROR: if (start) state_next = S_LEN_HI;
      S_LEN_HI:  if (xfer) state_next = S_LEN_LO;
      S_LEN_LO: begin
        if (xfer) begin
          if (len_word == 16'd0)        state_next = S_DONE;
          else if (len_word > MAX_LEN)  state_next = S_ERROR;
          else                          state_next = S_DATA_HI;
        end
      end
      S_DATA_HI: if (xfer) state_next = S_DATA_LO;
      S_DATA_LO: if (xfer) state_next = S_WRITE;
      S_WRITE: begin
`ifdef LOADER_CHECKSUM_EN
        state_next = last_word ? S_CHK_HI : S_DATA_HI;
`else
        state_next = last_word ? S_DONE : S_DATA_HI;
`endif
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHK_HI:  if (xfer) state_next = S_CHK_LO;
      S_CHK_LO:  if (xfer) state_next = (byte_word == sum_reg) ? S_DONE : S_ERROR;
`endif
      default:   state_next = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    wr_en    = 1'b0;
    busy     = 1'b1;
    done     = 1'b0;
    error    = 1'b0;
    case (state_reg)
      S_IDLE:    busy = 1'b0;
      S_DONE: begin
        busy = 1'b0;
        done = 1'b1;
      end
      S_ERROR:   error = 1'b1;
      S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO: in_ready = 1'b1;
`ifdef LOADER_CHECKSUM_EN
      S_CHK_HI, S_CHK_LO: in_ready = 1'b1;
`endif
      S_WRITE:   wr_en = 1'b1;
      default: ;
    endcase
    cpu_hold = busy;
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: table of byte streams with expected write/outcome results,
// plus hand-written sequences for reset mid-load, start handling and the 256-word boundary.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready;
  logic        wr_en;
  logic [15:0] wr_addr;
  logic [15:0] wr_data;
  logic        cpu_hold;
  logic        busy;
  logic        done;
  logic        error;

  imem_loader #(.ADDR_W(16), .MEM_WORDS(256)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .cpu_hold (cpu_hold),
    .busy     (busy),
    .done     (done),
    .error    (error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Write log captured mid-cycle; wr_en lasts exactly one cycle per word.
  logic [15:0] log_addr [0:1023];
  logic [15:0] log_data [0:1023];
  logic        log_hold [0:1023];
  int          wr_cnt = 0;

  always @(negedge clk) begin
    if (wr_en && wr_cnt < 1024) begin
      log_addr[wr_cnt] <= wr_addr;
      log_data[wr_cnt] <= wr_data;
      log_hold[wr_cnt] <= cpu_hold;
      wr_cnt <= wr_cnt + 1;
    end
  end

  typedef struct {
    logic [47:0] bytes;
    int          nb;
    int          gap_at;
    int          exp_wr;
    logic [15:0] exp_first;
    logic [15:0] exp_last_addr;
    logic [15:0] exp_last;
    bit          exp_done;
    bit          exp_err;
  } vec_t;

  vec_t        vecs [5];
  logic [7:0]  stream [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    in_valid = 1'b1;
    in_data  = b;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 20) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_byte_timeout: in_ready=0 required 1 for byte 0x%0h", b);
    end
    step();
  endtask

  task automatic send_stream(input int gap_at);
    for (int i = 0; i < stream.size(); i++) begin
      if (i == gap_at) begin
        in_valid = 1'b0;
        repeat (5) step();
      end
      send_byte(stream[i]);
    end
    in_valid = 1'b0;
    in_data  = 8'h00;
  endtask

`ifdef LOADER_CHECKSUM_EN
  task automatic add_checksum();
    logic [15:0] len;
    logic [15:0] sum;
    if (stream.size() >= 2) begin
      len = {stream[0], stream[1]};
      sum = 16'h0000;
      if (len >= 16'd1 && len <= 16'd256 && stream.size() == 2 + 2 * int'(len)) begin
        for (int w = 0; w < int'(len); w++) sum = sum + {stream[2 + 2 * w], stream[3 + 2 * w]};
        stream.push_back(sum[15:8]);
        stream.push_back(sum[7:0]);
      end
    end
  endtask
`endif

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_end(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (!(done || error) && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!(done || error)) begin
      checks++;
      errors++;
      $display("FAIL %s_end_timeout: done=0 error=0 required one of them high", name);
    end
  endtask

  task automatic check_result(input string name, input int base, input int exp_wr,
                              input logic [15:0] exp_first, input logic [15:0] exp_last_addr,
                              input logic [15:0] exp_last, input bit exp_done, input bit exp_err);
    int bad_hold;
    chk({name, "_done"},     32'(done),     32'(exp_done));
    chk({name, "_error"},    32'(error),    32'(exp_err));
    chk({name, "_cpu_hold"}, 32'(cpu_hold), 32'(exp_err));
    chk({name, "_busy"},     32'(busy),     32'(exp_err));
    chk({name, "_writes"},   32'(wr_cnt - base), 32'(exp_wr));
    if (exp_wr > 0 && wr_cnt > base) begin
      bad_hold = 0;
      for (int i = base; i < wr_cnt; i++) if (log_hold[i] !== 1'b1) bad_hold++;
      chk({name, "_first_addr"}, 32'(log_addr[base]), 32'h0);
      chk({name, "_first_data"}, 32'(log_data[base]), 32'(exp_first));
      chk({name, "_last_addr"},  32'(log_addr[wr_cnt - 1]), 32'(exp_last_addr));
      chk({name, "_last_data"},  32'(log_data[wr_cnt - 1]), 32'(exp_last));
      chk({name, "_hold_during_writes"}, 32'(bad_hold), 32'h0);
    end
    $display("txn %s: writes=%0d done=%0b error=%0b cpu_hold=%0b", name, wr_cnt - base, done, error, cpu_hold);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int    base;
    string name;
    name = $sformatf("vec%0d", idx);
    base = wr_cnt;
    pulse_start();
    @(negedge clk);
    chk({name, "_busy_after_start"},  32'(busy),  32'h1);
    chk({name, "_done_cleared"},      32'(done),  32'h0);
    chk({name, "_error_cleared"},     32'(error), 32'h0);
    step();
    stream.delete();
    for (int i = 0; i < v.nb; i++) stream.push_back(v.bytes[47 - 8 * i -: 8]);
`ifdef LOADER_CHECKSUM_EN
    add_checksum();
`endif
    send_stream(v.gap_at);
    wait_end(name);
    check_result(name, base, v.exp_wr, v.exp_first, v.exp_last_addr, v.exp_last, v.exp_done, v.exp_err);
    step();
  endtask

  initial begin
    int base;
    logic [15:0] w;
    int bad_data;

    vecs[0] = '{48'h0002_1234_ABCD, 6, -1, 2, 16'h1234, 16'h0001, 16'hABCD, 1'b1, 1'b0};
    vecs[1] = '{48'h0002_1234_ABCD, 6,  3, 2, 16'h1234, 16'h0001, 16'hABCD, 1'b1, 1'b0};
    vecs[2] = '{48'h0101_0000_0000, 2, -1, 0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b1};
    vecs[3] = '{48'h0000_0000_0000, 2, -1, 0, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0};
    vecs[4] = '{48'h0001_FFFF_0000, 4, -1, 1, 16'hFFFF, 16'h0000, 16'hFFFF, 1'b1, 1'b0};

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_in_ready", 32'(in_ready), 32'h0);
    chk("reset_wr_en",    32'(wr_en),    32'h0);
    chk("reset_wr_addr",  32'(wr_addr),  32'h0);
    chk("reset_wr_data",  32'(wr_data),  32'h0);
    chk("reset_cpu_hold", 32'(cpu_hold), 32'h0);
    chk("reset_busy",     32'(busy),     32'h0);
    chk("reset_done",     32'(done),     32'h0);
    chk("reset_error",    32'(error),    32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    step();

    for (int i = 0; i < 5; i++) begin
      run_vec(i, vecs[i]);
      if (i == 2) begin
        // After a rejected length the loader must refuse further bytes.
        in_valid = 1'b1;
        in_data  = 8'h55;
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          chk($sformatf("err_refuse_in_ready_%0d", k), 32'(in_ready), 32'h0);
        end
        chk("err_refuse_still_error", 32'(error), 32'h1);
        step();
        in_valid = 1'b0;
      end
    end

    // Reset while in DATA_LO of word 1.
    base = wr_cnt;
    pulse_start();
    stream.delete();
    stream = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB};
    send_stream(-1);
    chk("midreset_writes_before", 32'(wr_cnt - base), 32'h1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("midreset_busy",     32'(busy),     32'h0);
    chk("midreset_cpu_hold", 32'(cpu_hold), 32'h0);
    chk("midreset_wr_en",    32'(wr_en),    32'h0);
    chk("midreset_in_ready", 32'(in_ready), 32'h0);
    $display("txn midreset: busy=%0b cpu_hold=%0b wr_en=%0b", busy, cpu_hold, wr_en);
    step();
    run_vec(10, vecs[0]);

    // start during DATA_HI must be ignored; otherwise 12 34 would become a length and error out.
    base = wr_cnt;
    pulse_start();
    stream.delete();
    stream = '{8'h00, 8'h01};
    send_stream(-1);
    pulse_start();
    @(negedge clk);
    chk("ignstart_busy", 32'(busy), 32'h1);
    step();
    stream.delete();
    stream = '{8'h12, 8'h34};
`ifdef LOADER_CHECKSUM_EN
    stream.push_back(8'h12);
    stream.push_back(8'h34);
`endif
    send_stream(-1);
    wait_end("ignstart");
    check_result("ignstart", base, 1, 16'h1234, 16'h0000, 16'h1234, 1'b1, 1'b0);
    step();

    // Full-depth load: 256 words, word i = {i, ~i}.
    base = wr_cnt;
    pulse_start();
    stream.delete();
    stream.push_back(8'h01);
    stream.push_back(8'h00);
    for (int i = 0; i < 256; i++) begin
      w = {8'(i), ~8'(i)};
      stream.push_back(w[15:8]);
      stream.push_back(w[7:0]);
    end
`ifdef LOADER_CHECKSUM_EN
    add_checksum();
`endif
    send_stream(-1);
    wait_end("full256");
    check_result("full256", base, 256, 16'h00FF, 16'h00FF, 16'hFF00, 1'b1, 1'b0);
    bad_data = 0;
    for (int i = 0; i < 256 && base + i < wr_cnt; i++) begin
      w = {8'(i), ~8'(i)};
      if (log_addr[base + i] !== 16'(i) || log_data[base + i] !== w) bad_data++;
    end
    chk("full256_all_words", 32'(bad_data), 32'h0);
    step();

`ifdef LOADER_CHECKSUM_EN
    base = wr_cnt;
    pulse_start();
    stream.delete();
    stream = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hBE, 8'h01};
    send_stream(-1);
    wait_end("chk_good");
    check_result("chk_good", base, 2, 16'h1234, 16'h0001, 16'hABCD, 1'b1, 1'b0);
    step();

    base = wr_cnt;
    pulse_start();
    stream.delete();
    stream = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hBE, 8'h00};
    send_stream(-1);
    wait_end("chk_bad");
    check_result("chk_bad", base, 2, 16'h1234, 16'h0001, 16'hABCD, 1'b0, 1'b1);
    step();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
